// File: rtl/mean_filter_ctrl.sv
// mean_filter_ctrl: control plane for a box (mean) filter.
// Holds the active kernel size and its divide-by-area constants, follows the
// input frame with an IDLE/ACTIVE/DRAIN machine, counts pixels and lines, and
// flags illegal configs and stream protocol violations.
module mean_filter_ctrl #(
  parameter int CW       = 12,
  parameter int KSZ_INIT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  input  logic [2:0]    cfg_ksz,
  output logic          cfg_ready,
  input  logic          din_vsync,
  input  logic          din_hsync,
  output logic [2:0]    ksz_active,
  output logic [7:0]    recip,
  output logic [2:0]    lat,
  output logic          busy,
  output logic [CW-1:0] pix_cnt,
  output logic [CW-1:0] line_cnt,
  output logic          frame_done,
  output logic          cfg_err,
  output logic          sync_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DRAIN = 2'd2} state_t;

  localparam logic [2:0]    KSZ_RST = 3'(KSZ_INIT);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // round(1024 / k^2) for the supported kernels
  function automatic logic [7:0] recip_of(input logic [2:0] k);
    case (k)
      3'd5:    recip_of = 8'd41;
      3'd7:    recip_of = 8'd21;
      default: recip_of = 8'd114;
    endcase
  endfunction

  // divide-by-area pipeline depth for each kernel
  function automatic logic [2:0] lat_of(input logic [2:0] k);
    lat_of = (k == 3'd3) ? 3'd6 : 3'd5;
  endfunction

  function automatic logic ksz_legal(input logic [2:0] k);
    ksz_legal = (k == 3'd3) || (k == 3'd5) || (k == 3'd7);
  endfunction

  state_t      state, state_nxt;
  logic        vsync_p1, hsync_p1;
  logic [2:0]  drain_cnt;
  logic        pend;
  logic [2:0]  pend_ksz;
  logic        vs_rise, vs_fall, hs_fall;
  logic        cfg_acc, drain_done, apply_cfg;

  assign vs_rise    = din_vsync & ~vsync_p1;
  assign vs_fall    = ~din_vsync & vsync_p1;
  assign hs_fall    = ~din_hsync & hsync_p1;
  assign cfg_ready  = ~pend;
  assign cfg_acc    = cfg_valid & cfg_ready;
  assign drain_done = (state == DRAIN) && (drain_cnt == lat - 3'd1);
  // A pending kernel lands in IDLE or at the end of DRAIN, never when a new
  // frame is starting on the same edge.
  assign apply_cfg  = pend && !vs_rise && ((state == IDLE) || drain_done);

  // stage p1: previous-cycle syncs for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_p1 <= 1'b0;
      hsync_p1 <= 1'b0;
    end else begin
      vsync_p1 <= din_vsync;
      hsync_p1 <= din_hsync;
    end
  end

  // frame state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // frame next-state logic; a vsync rise in DRAIN restarts the frame at once
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (vs_rise) state_nxt = ACTIVE;
      ACTIVE:  if (vs_fall) state_nxt = DRAIN;
      DRAIN: begin
        if (vs_rise)         state_nxt = ACTIVE;
        else if (drain_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // frame state outputs
  always_comb begin
    busy = (state != IDLE);
  end

  // cycles spent in DRAIN so far; zero on the first DRAIN cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 drain_cnt <= 3'd0;
    else if (state == DRAIN) drain_cnt <= drain_cnt + 3'd1;
    else                     drain_cnt <= 3'd0;
  end

  // config slot, active kernel and its derived constants
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend       <= 1'b0;
      ksz_active <= KSZ_RST;
      recip      <= recip_of(KSZ_RST);
      lat        <= lat_of(KSZ_RST);
      cfg_err    <= 1'b0;
    end else begin
      cfg_err <= cfg_acc & ~ksz_legal(cfg_ksz);
      if (apply_cfg) begin
        pend       <= 1'b0;
        ksz_active <= pend_ksz;
        recip      <= recip_of(pend_ksz);
        lat        <= lat_of(pend_ksz);
      end else if (cfg_acc && ksz_legal(cfg_ksz)) begin
        pend <= 1'b1;
      end
    end
  end

  // captured kernel value; only meaningful while pend is set
  always_ff @(posedge clk) begin
    if (cfg_acc && ksz_legal(cfg_ksz)) pend_ksz <= cfg_ksz;
  end

  // saturating pixel and line counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
    end else if (vs_rise) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
    end else begin
      if (hs_fall)
        pix_cnt <= '0;
      else if (state == ACTIVE && din_hsync && pix_cnt != CNT_MAX)
        pix_cnt <= pix_cnt + CNT_ONE;
      if (state == ACTIVE && hs_fall && line_cnt != CNT_MAX)
        line_cnt <= line_cnt + CNT_ONE;
    end
  end

  // one-cycle status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      frame_done <= drain_done & ~vs_rise;
      sync_err   <= (din_hsync & ~din_vsync) | ((state == DRAIN) & vs_rise);
    end
  end

endmodule

// File: tb/tb_mean_filter_ctrl.sv
// Testbench for mean_filter_ctrl: frame-level stimulus with a scoreboard of
// expected pulses and line-end counts, checked by an independent monitor.
module tb_mean_filter_ctrl;
  localparam int CW    = 5;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int KINIT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic [2:0]    cfg_ksz = 3'd0;
  logic          cfg_ready;
  logic          din_vsync = 1'b0;
  logic          din_hsync = 1'b0;
  logic [2:0]    ksz_active;
  logic [7:0]    recip;
  logic [2:0]    lat;
  logic          busy;
  logic [CW-1:0] pix_cnt, line_cnt;
  logic          frame_done, cfg_err, sync_err;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;
  int pix_prev = 0;

  // kind 1 = frame_done, 2 = cfg_err, 3 = sync_err
  typedef struct { int kind; int cyc; int a; int b; int c; int d; } ev_t;
  typedef struct { int len; int line; } ln_t;
  ev_t ev_q[$];
  ln_t ln_q[$];

  // reference model of the block's visible configuration state
  int m_ksz = KINIT;
  int m_pend = 0;
  int m_pend_ksz = 0;
  int m_line = 0;

  mean_filter_ctrl #(.CW(CW), .KSZ_INIT(KINIT)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ksz(cfg_ksz),
    .cfg_ready(cfg_ready), .din_vsync(din_vsync), .din_hsync(din_hsync),
    .ksz_active(ksz_active), .recip(recip), .lat(lat), .busy(busy),
    .pix_cnt(pix_cnt), .line_cnt(line_cnt), .frame_done(frame_done),
    .cfg_err(cfg_err), .sync_err(sync_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int exp_recip(input int k);
    return (2048 / (k * k) + 1) / 2;
  endfunction
  function automatic int exp_lat(input int k);
    return (k == 3) ? 6 : 5;
  endfunction
  function automatic bit legal(input int k);
    return (k == 3) || (k == 5) || (k == 7);
  endfunction
  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int kind, input int c, input int a, input int b,
                         input int cc, input int d);
    ev_t e;
    e.kind = kind; e.cyc = c; e.a = a; e.b = b; e.c = cc; e.d = d;
    ev_q.push_back(e);
  endtask

  task automatic check_static(input string tag);
    chk({tag, " ksz_active"}, ksz_active, m_ksz);
    chk({tag, " recip"}, recip, exp_recip(m_ksz));
    chk({tag, " lat"}, lat, exp_lat(m_ksz));
    chk({tag, " cfg_ready"}, cfg_ready, m_pend ? 0 : 1);
  endtask

  // monitor: pops one expectation per DUT pulse or per pixel-counter clear
  task automatic pop_ev(input int kind);
    ev_t e;
    if (ev_q.size() == 0) begin
      ntests++; nfail++;
      $display("FAIL unexpected pulse: kind %0d at cycle %0d, expected none", kind, cyc);
      return;
    end
    e = ev_q.pop_front();
    chk("event kind", kind, e.kind);
    chk("event cycle", cyc, e.cyc);
    if (kind == 1) begin
      chk("frame_done ksz_active", ksz_active, e.a);
      chk("frame_done recip", recip, e.b);
      chk("frame_done lat", lat, e.c);
      chk("frame_done line_cnt", line_cnt, e.d);
      chk("frame_done busy", busy, 0);
    end else if (kind == 2) begin
      chk("cfg_err ksz_active", ksz_active, e.a);
      chk("cfg_err cfg_ready", cfg_ready, 1);
    end else begin
      chk("sync_err pix_cnt", pix_cnt, e.a);
      chk("sync_err line_cnt", line_cnt, e.b);
    end
  endtask

  always @(negedge clk) begin
    ln_t l;
    if (!rst) begin
      if (frame_done) pop_ev(1);
      if (cfg_err)    pop_ev(2);
      if (sync_err)   pop_ev(3);
      if (pix_prev != 0 && pix_cnt == 0) begin
        if (ln_q.size() == 0) begin
          ntests++; nfail++;
          $display("FAIL unexpected line end: pix_cnt was %0d at cycle %0d, expected none", pix_prev, cyc);
        end else begin
          l = ln_q.pop_front();
          chk("line end pix_cnt", pix_prev, l.len);
          chk("line end line_cnt", line_cnt, l.line);
        end
      end
    end
    pix_prev <= int'(pix_cnt);
  end

  // config write while idle with nothing pending
  task automatic cfg_write(input int k);
    cfg_valid = 1'b1;
    cfg_ksz   = 3'(k);
    if (!legal(k)) push_ev(2, cyc + 1, m_ksz, 0, 0, 0);
    tick();
    cfg_valid = 1'b0;
    if (legal(k)) begin
      chk("cfg accepted cfg_ready", cfg_ready, 0);
      chk("cfg accepted ksz_active", ksz_active, m_ksz);
      tick();
      m_ksz = k;
      check_static("cfg applied");
    end else begin
      check_static("cfg rejected");
    end
  endtask

  task automatic frame_start(input int cfg_k);
    din_vsync = 1'b1;
    if (cfg_k != 0) begin
      cfg_valid = 1'b1;
      cfg_ksz   = 3'(cfg_k);
      if (!legal(cfg_k)) push_ev(2, cyc + 1, m_ksz, 0, 0, 0);
    end
    tick();
    cfg_valid = 1'b0;
    if (cfg_k != 0 && legal(cfg_k)) begin
      m_pend = 1;
      m_pend_ksz = cfg_k;
    end
    m_line = 0;
    chk("frame start busy", busy, 1);
    chk("frame start pix_cnt", pix_cnt, 0);
    chk("frame start line_cnt", line_cnt, 0);
    tick();
    check_static("frame start");
  endtask

  task automatic lines(input int nl, input int lmin, input int lmax, input int cfg_mid);
    int len;
    ln_t l;
    for (int i = 0; i < nl; i++) begin
      len = $urandom_range(lmax, lmin);
      m_line++;
      l.len = sat(len);
      l.line = sat(m_line);
      ln_q.push_back(l);
      din_hsync = 1'b1;
      repeat (len) tick();
      din_hsync = 1'b0;
      if (i == nl / 2 && cfg_mid != 0 && m_pend == 0) begin
        cfg_valid = 1'b1;
        cfg_ksz   = 3'(cfg_mid);
        if (!legal(cfg_mid)) push_ev(2, cyc + 1, m_ksz, 0, 0, 0);
        tick();
        cfg_valid = 1'b0;
        if (legal(cfg_mid)) begin
          m_pend = 1;
          m_pend_ksz = cfg_mid;
        end
      end else begin
        tick();
      end
      check_static("in frame");
      repeat ($urandom_range(2, 0)) tick();
    end
  endtask

  task automatic frame_end(input bit rerise);
    int L;
    int n;
    int ka;
    L  = exp_lat(m_ksz);
    n  = cyc;
    ka = m_pend ? m_pend_ksz : m_ksz;
    din_vsync = 1'b0;
    if (!rerise) push_ev(1, n + 1 + L, ka, exp_recip(ka), exp_lat(ka), sat(m_line));
    tick();
    chk("drain entry busy", busy, 1);
    if (rerise) begin
      tick();
      din_vsync = 1'b1;
      push_ev(3, cyc + 1, 0, 0, 0, 0);
      tick();
      m_line = 0;
      chk("rerise busy", busy, 1);
      check_static("rerise");
      repeat (L + 2) tick();
      chk("rerise still active", busy, 1);
      chk("rerise line_cnt", line_cnt, 0);
    end else begin
      repeat (L - 1) tick();
      chk("drain last cycle busy", busy, 1);
      tick();
      m_ksz  = ka;
      m_pend = 0;
      chk("drain done busy", busy, 0);
      check_static("frame end");
      chk("frame end line_cnt", line_cnt, sat(m_line));
    end
  endtask

  task automatic idle_hsync();
    din_hsync = 1'b1;
    push_ev(3, cyc + 1, 0, sat(m_line), 0, 0);
    tick();
    din_hsync = 1'b0;
    tick();
    tick();
    chk("idle hsync pix_cnt", pix_cnt, 0);
    chk("idle hsync line_cnt", line_cnt, sat(m_line));
    chk("idle hsync busy", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int ks_tab[4];
    int km_tab[7];
    int nl;
    ks_tab = '{0, 3, 5, 7};
    km_tab = '{0, 3, 4, 5, 6, 7, 1};

    // reset values
    tick(); tick();
    check_static("reset");
    chk("reset busy", busy, 0);
    chk("reset pix_cnt", pix_cnt, 0);
    chk("reset line_cnt", line_cnt, 0);
    chk("reset frame_done", frame_done, 0);
    chk("reset cfg_err", cfg_err, 0);
    chk("reset sync_err", sync_err, 0);
    rst = 1'b0;
    tick(); tick();

    // idle config write, then back to 3
    cfg_write(5);
    cfg_write(3);

    // 4 lines x 10 pixels with a mid-frame request for 7
    frame_start(0);
    lines(4, 10, 10, 7);
    frame_end(0);

    // illegal kernel and stray hsync outside a frame
    cfg_write(4);
    idle_hsync();

    // request coincident with frame start waits for the frame end
    frame_start(5);
    lines(2, 2, 6, 0);
    frame_end(0);

    // vsync re-rise during drain with a pending config
    cfg_write(7);
    frame_start(0);
    lines(2, 3, 8, 5);
    frame_end(1);
    lines(1, 2, 4, 0);
    frame_end(0);

    // counter saturation
    frame_start(0);
    lines(1, 40, 40, 0);
    lines(32, 1, 2, 0);
    frame_end(0);

    // randomized frames
    for (int f = 0; f < 8; f++) begin
      nl = $urandom_range(5, 1);
      frame_start(ks_tab[$urandom_range(3, 0)]);
      lines(nl, 1, 12, km_tab[$urandom_range(6, 0)]);
      frame_end(0);
      if ($urandom_range(1, 0) == 1) cfg_write($urandom_range(7, 0));
      else idle_hsync();
      repeat ($urandom_range(3, 1)) tick();
    end

    // reset in the middle of a frame with a pending config
    if (m_ksz == 3) cfg_write(7);
    frame_start(0);
    lines(2, 3, 6, (m_ksz == 5) ? 7 : 5);
    rst = 1'b1;
    #1;
    chk("async reset busy", busy, 0);
    chk("async reset ksz_active", ksz_active, KINIT);
    chk("async reset cfg_ready", cfg_ready, 1);
    m_ksz = KINIT;
    m_pend = 0;
    m_line = 0;
    din_vsync = 1'b0;
    din_hsync = 1'b0;
    tick();
    check_static("mid-frame reset");
    chk("mid-frame reset pix_cnt", pix_cnt, 0);
    chk("mid-frame reset line_cnt", line_cnt, 0);
    chk("mid-frame reset frame_done", frame_done, 0);
    rst = 1'b0;
    repeat (8) tick();
    check_static("after reset release");
    chk("after reset release busy", busy, 0);

    repeat (4) tick();
    chk("pulse queue drained", ev_q.size(), 0);
    chk("line queue drained", ln_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
